// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, decoder FSM states and byte-count helper.
package kyber_pkg;
    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int DU = 10;
    localparam int DV = 4;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    function automatic int decompress_bytes(input int d, input int n = KYBER_N);
        return n * d / 8;
    endfunction
endpackage

// File: rtl/poly_decompress_core.sv
// poly_decompress_core: maps a D-bit compressed value x to round(x*Q/2^D), ties rounding up.
module poly_decompress_core
    import kyber_pkg::*;
#(
    parameter int D = 10,
    parameter int Q = KYBER_Q,
    parameter int COEF_W = 12
) (
    input  logic [D-1:0]      x,
    output logic [COEF_W-1:0] coef
);
    localparam int PW = D + 12;
    logic [PW-1:0] prod;
    assign prod = PW'(x) * PW'(Q) + (PW'(1) << (D - 1));
    assign coef = COEF_W'(prod >> D);
endmodule

// File: rtl/poly_decompress_stream.sv
// poly_decompress_stream: unpacks N LSB-first D-bit coefficients from a byte stream and decompresses them.
// Defining POLY_DECOMP_RAW_EN adds out_raw, the compressed value registered alongside out_coef.
module poly_decompress_stream
    import kyber_pkg::*;
#(
    parameter int D = 10,
    parameter int Q = KYBER_Q,
    parameter int N = KYBER_N,
    parameter int COEF_W = 12,
    parameter int BUF_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [COEF_W-1:0] out_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_idx,
    output logic              busy,
    output logic              done
`ifdef POLY_DECOMP_RAW_EN
    ,
    output logic [D-1:0]      out_raw
`endif
);
    localparam int NB = decompress_bytes(D, N);
    localparam int BCW = $clog2(BUF_W + 1);
    localparam int CW = $clog2(NB + 1);
    localparam int KW = $clog2(N + 1);
    state_t state;
    logic [BUF_W-1:0] acc_buf, buf_n;
    logic [BCW-1:0] bitcnt, bitcnt_n, pos;
    logic [CW-1:0] bytecnt;
    logic [KW-1:0] coefcnt;
    logic acc, ext, fin;
    logic [COEF_W-1:0] coef;
    assign busy = state != IDLE;
    assign in_ready = state == RUN && bytecnt < CW'(NB) && bitcnt <= BCW'(BUF_W - 8);
    assign acc = in_valid && in_ready;
    assign ext = busy && bitcnt >= BCW'(D) && coefcnt < KW'(N) && (!out_valid || out_ready);
    assign fin = state == DRAIN && coefcnt == KW'(N) && out_valid && out_ready;
    // the new byte lands just above whatever survives this cycle's extraction
    assign pos = bitcnt - (ext ? BCW'(D) : '0);
    assign bitcnt_n = pos + (acc ? BCW'(8) : '0);
    assign buf_n = (ext ? acc_buf >> D : acc_buf) | (acc ? BUF_W'(in_data) << pos : '0);
    poly_decompress_core #(.D(D), .Q(Q), .COEF_W(COEF_W)) u_core (
        .x(acc_buf[D-1:0]),
        .coef(coef)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc_buf <= '0;
            bitcnt <= '0;
            bytecnt <= '0;
            coefcnt <= '0;
            out_valid <= 1'b0;
            out_coef <= '0;
            out_idx <= '0;
            done <= 1'b0;
`ifdef POLY_DECOMP_RAW_EN
            out_raw <= '0;
`endif
        end else begin
            done <= fin;
            if (state == IDLE) begin
                acc_buf <= '0;
                bitcnt <= '0;
                bytecnt <= '0;
                coefcnt <= '0;
                if (start) state <= RUN;
            end else begin
                acc_buf <= buf_n;
                bitcnt <= bitcnt_n;
                if (acc) bytecnt <= bytecnt + 1'b1;
                if (ext) coefcnt <= coefcnt + 1'b1;
                if (state == RUN && acc && bytecnt == CW'(NB - 1)) state <= DRAIN;
                if (fin) state <= IDLE;
            end
            if (ext) begin
                out_valid <= 1'b1;
                out_coef <= coef;
                out_idx <= 8'(coefcnt);
`ifdef POLY_DECOMP_RAW_EN
                out_raw <= acc_buf[D-1:0];
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
    // every legal D packs N coefficients into whole bytes, so nothing may be left over
    assert property (@(posedge clk) disable iff (rst) fin |-> bitcnt == '0);
endmodule

// File: tb/tb_poly_decompress_stream.sv
// tb_poly_decompress_stream: checks five decoder instances (D=1,4,5,10,11) against a bit-queue reference model.
module tb_poly_decompress_stream;
    function automatic int dof(input int k);
        return k == 0 ? 1 : k == 1 ? 4 : k == 2 ? 5 : k == 3 ? 10 : 11;
    endfunction
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start [5];
    logic [7:0] in_data [5];
    logic in_valid [5];
    logic in_ready [5];
    logic [11:0] out_coef [5];
    logic out_valid [5];
    logic out_ready [5];
    logic [7:0] out_idx [5];
    logic busy [5];
    logic done [5];
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] byte_q [$];
    int got [256];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 5; g++) begin : g_dut
        poly_decompress_stream #(.D(dof(g))) dut (
            .clk(clk), .rst(rst), .start(start[g]),
            .in_data(in_data[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .out_coef(out_coef[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_idx(out_idx[g]), .busy(busy[g]), .done(done[g])
        );
    end
    task automatic fill_const(input int k, input logic [7:0] v);
        byte_q = {};
        for (int i = 0; i < 32 * dof(k); i++) byte_q.push_back(v);
    endtask
    task automatic fill_rand(input int k);
        byte_q = {};
        for (int i = 0; i < 32 * dof(k); i++) byte_q.push_back(8'($urandom));
    endtask
    task automatic run_poly(input int k, input int ivp, input int orp, input int stall_at, input bit sb, input string nm);
        int d, nb, bi, oi, cyc, ndone, post, stall;
        bit stalled;
        longint x;
        bit bits [$];
        int expv [256];
        logic [11:0] hold_c;
        logic [7:0] hold_i;
        d = dof(k);
        nb = 32 * d;
        for (int i = 0; i < nb; i++)
            for (int j = 0; j < 8; j++) bits.push_back(byte_q[i][j]);
        for (int i = 0; i < 256; i++) begin
            x = 0;
            for (int j = 0; j < d; j++) x |= longint'(bits[i*d+j]) << j;
            expv[i] = int'((2 * x * 3329 + (longint'(1) << d)) / (longint'(1) << (d + 1)));
        end
        @(negedge clk);
        start[k] = 1'b1;
        bi = 0; oi = 0; cyc = 0; ndone = 0; post = 0; stall = 0; stalled = 0;
        while (cyc < 6000 && post < 4) begin
            @(negedge clk);
            cyc++;
            start[k] = sb && cyc == 20;
            in_valid[k] = bi < nb && (stall > 0 || $urandom_range(99) < ivp);
            in_data[k] = bi < nb ? byte_q[bi] : 8'h00;
            if (!stalled && stall_at >= 0 && out_valid[k] && oi == stall_at) begin
                stalled = 1;
                stall = 20;
                hold_c = out_coef[k];
                hold_i = out_idx[k];
            end
            if (stall > 0) begin
                out_ready[k] = 1'b0;
                stall--;
                if (stall == 0) begin
                    n_cmp++;
                    if (out_valid[k] !== 1'b1 || out_coef[k] !== hold_c || out_idx[k] !== hold_i) begin
                        n_bad++;
                        $display("FAIL %s hold: coef %0d idx %0d valid %b, want coef %0d idx %0d valid 1", nm, out_coef[k], out_idx[k], out_valid[k], hold_c, hold_i);
                    end
                    n_cmp++;
                    if (in_ready[k] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s in_ready under backpressure: got %b want 0", nm, in_ready[k]);
                    end
                end
            end else begin
                out_ready[k] = $urandom_range(99) < orp;
            end
            if (in_valid[k] && in_ready[k]) bi++;
            if (out_valid[k] && out_ready[k]) begin
                n_cmp++;
                if (oi >= 256) begin
                    n_bad++;
                    $display("FAIL %s extra output idx %0d, want none", nm, out_idx[k]);
                end else begin
                    if (out_coef[k] !== 12'(expv[oi]) || out_idx[k] !== 8'(oi)) begin
                        n_bad++;
                        $display("FAIL %s coef: got %0d idx %0d, want %0d idx %0d", nm, out_coef[k], out_idx[k], expv[oi], oi);
                    end
                    got[oi] = int'(out_coef[k]);
                    oi++;
                end
            end
            if (done[k]) begin
                ndone++;
                n_cmp++;
                if (oi != 256 || busy[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s done: outputs %0d busy %b, want 256 busy 0", nm, oi, busy[k]);
                end
            end
            if (oi == 256 && ndone > 0) post++;
        end
        start[k] = 1'b0;
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b0;
        n_cmp++;
        if (oi != 256 || ndone != 1 || bi != nb) begin
            n_bad++;
            $display("FAIL %s completion: outputs %0d done %0d bytes %0d, want 256 1 %0d", nm, oi, ndone, bi, nb);
        end
    endtask
    task automatic test_reset;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (out_valid[k] !== 0 || out_coef[k] !== 0 || out_idx[k] !== 0 || done[k] !== 0 || busy[k] !== 0 || in_ready[k] !== 0) begin
                n_bad++;
                $display("FAIL reset D=%0d: v%b c%0d i%0d d%b b%b r%b, want all 0", dof(k), out_valid[k], out_coef[k], out_idx[k], done[k], busy[k], in_ready[k]);
            end
        end
    endtask
    task automatic test_d10;
        fill_const(3, 8'h00);
        byte_q[0] = 8'hFF; byte_q[1] = 8'h03; byte_q[2] = 8'h01;
        run_poly(3, 100, 100, -1, 0, "d10_vector");
        n_cmp++;
        if (got[0] != 3326 || got[1] != 208 || got[2] != 0) begin
            n_bad++;
            $display("FAIL d10_known: got %0d %0d %0d, want 3326 208 0", got[0], got[1], got[2]);
        end
    endtask
    task automatic test_d11_ones;
        fill_const(4, 8'hFF);
        run_poly(4, 100, 100, -1, 0, "d11_ones");
        n_cmp++;
        if (got[0] != 3327 || got[255] != 3327) begin
            n_bad++;
            $display("FAIL d11_known: got %0d %0d, want 3327 3327", got[0], got[255]);
        end
    endtask
    task automatic test_small_d;
        fill_const(1, 8'h08);
        run_poly(1, 100, 100, -1, 0, "d4_alt");
        n_cmp++;
        if (got[0] != 1665 || got[1] != 0 || got[254] != 1665 || got[255] != 0) begin
            n_bad++;
            $display("FAIL d4_known: got %0d %0d %0d %0d, want 1665 0 1665 0", got[0], got[1], got[254], got[255]);
        end
        fill_const(0, 8'h01);
        run_poly(0, 100, 100, -1, 0, "d1_sparse");
        n_cmp++;
        if (got[0] != 1665 || got[1] != 0 || got[7] != 0 || got[8] != 1665) begin
            n_bad++;
            $display("FAIL d1_known: got %0d %0d %0d %0d, want 1665 0 0 1665", got[0], got[1], got[7], got[8]);
        end
    endtask
    task automatic test_backpressure;
        fill_rand(2);
        run_poly(2, 100, 100, 50, 0, "d5_backpressure");
    endtask
    task automatic test_reset_mid;
        int bi, cyc;
        bit hit;
        fill_rand(3);
        @(negedge clk);
        start[3] = 1'b1;
        bi = 0; cyc = 0; hit = 0;
        while (cyc < 2000 && !hit) begin
            @(negedge clk);
            cyc++;
            start[3] = 1'b0;
            hit = out_valid[3] && out_idx[3] == 8'd100;
            in_valid[3] = bi < 320;
            in_data[3] = bi < 320 ? byte_q[bi] : 8'h00;
            out_ready[3] = 1'b1;
            if (!hit && in_valid[3] && in_ready[3]) bi++;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL reset_mid reach idx 100: timed out, want idx 100 visible");
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid[3] !== 0 || out_coef[3] !== 0 || out_idx[3] !== 0 || busy[3] !== 0 || in_ready[3] !== 0 || done[3] !== 0) begin
            n_bad++;
            $display("FAIL reset_mid async: v%b c%0d i%0d b%b r%b d%b, want all 0", out_valid[3], out_coef[3], out_idx[3], busy[3], in_ready[3], done[3]);
        end
        in_valid[3] = 1'b0;
        out_ready[3] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fill_rand(3);
        run_poly(3, 100, 100, -1, 0, "d10_after_reset");
    endtask
    task automatic test_random;
        for (int k = 0; k < 5; k++) begin
            fill_rand(k);
            run_poly(k, 50, 50, -1, 1, $sformatf("random_d%0d", dof(k)));
        end
    endtask
    initial begin
        for (int k = 0; k < 5; k++) begin
            start[k] = 1'b0;
            in_data[k] = 8'h00;
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b0;
        end
        #1;
        test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_d10;
        test_d11_ones;
        test_small_d;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
